// File: rtl/digital_pfd_counter_pkg.sv
// ---------------------------------------------------------------------------
// digital_pfd_counter_pkg
//   Shared definitions for the Tiny-PLL phase-frequency detector.
//   - pfd_state_e : detector FSM encoding (IDLE / LEAD_REF / LEAD_FB)
//   - pfd_err_max : largest magnitude a signed ERR_WIDTH phase error may
//                   carry (2^(ERR_WIDTH-1)-1). The loop filter reuses it
//                   so both blocks clip at the same point.
// ---------------------------------------------------------------------------
package digital_pfd_counter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } pfd_state_e;

  function automatic int unsigned pfd_err_max(input int unsigned err_width);
    return (32'd1 << (err_width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/digital_pfd_counter_edge_sync.sv
// ---------------------------------------------------------------------------
// digital_pfd_counter_edge_sync
//   Brings one asynchronous clock-like input into the clk_in domain and
//   produces a single-cycle pulse for each rising edge seen.
//   Edge-to-rise latency is SYNC_STAGES+1 clk_in cycles, so two instances
//   with the same SYNC_STAGES stay matched.
// Ports
//   clk_in    in  1  sampling clock
//   rst_n     in  1  asynchronous active-low reset
//   async_in  in  1  asynchronous input (ref_clk or fb_clk)
//   rise      out 1  registered one-cycle rising-edge pulse
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module digital_pfd_counter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_d_p1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0   <= '0;
      sync_d_p1 <= 1'b0;
      rise      <= 1'b0;
    end else begin
      // synchronizer chain; MSB is the metastability-safe sample
      sync_p0   <= {sync_p0[SYNC_STAGES-2:0], async_in};
      // delayed copy for edge detection
      sync_d_p1 <= sync_p0[SYNC_STAGES-1];
      // registered rise pulse
      rise      <= sync_p0[SYNC_STAGES-1] & ~sync_d_p1;
    end
  end

endmodule

// File: rtl/digital_pfd_counter.sv
// ---------------------------------------------------------------------------
// digital_pfd_counter
//   Digital phase-frequency detector sitting after the feedback divider.
//   Counts clk_in cycles between the rising edges of ref_clk and fb_clk and
//   reports the signed difference (+ ref leads, - fb leads), saturating at
//   +/-(2^(ERR_WIDTH-1)-1). Also drives UP/DN levels while an edge is
//   outstanding.
// Ports
//   clk_in     in  1          fast DCO clock, sole clock
//   rst_n      in  1          asynchronous active-low reset
//   ref_clk    in  1          reference clock (asynchronous)
//   fb_clk     in  1          divided feedback clock (asynchronous)
//   up         out 1          ref edge seen, fb edge outstanding
//   dn         out 1          fb edge seen, ref edge outstanding
//   phase_err  out ERR_WIDTH  signed phase error, held between updates
//   err_valid  out 1          one-cycle pulse when phase_err updates
//   sat        out 1          valid with err_valid: clipped or frequency slip
// ---------------------------------------------------------------------------
module digital_pfd_counter
  import digital_pfd_counter_pkg::*;
#(
  parameter int ERR_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        ref_clk,
  input  logic                        fb_clk,
  output logic                        up,
  output logic                        dn,
  output logic signed [ERR_WIDTH-1:0] phase_err,
  output logic                        err_valid,
  output logic                        sat
);

  // Counter is unsigned and one bit narrower than phase_err, so its
  // all-ones value is exactly the positive clip level and negation can
  // never produce -2^(ERR_WIDTH-1).
  localparam int            CW      = ERR_WIDTH - 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(pfd_err_max(ERR_WIDTH));
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  function automatic logic signed [ERR_WIDTH-1:0] signed_mag(
    input logic [CW-1:0] mag,
    input logic          neg
  );
    logic signed [ERR_WIDTH-1:0] m;
    m = $signed({1'b0, mag});
    return neg ? -m : m;
  endfunction

  // ---- stage p1: synchronized rising-edge pulses ----
  logic rise_ref_p1;
  logic rise_fb_p1;

  digital_pfd_counter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (ref_clk),
    .rise     (rise_ref_p1)
  );

  digital_pfd_counter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fb (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (fb_clk),
    .rise     (rise_fb_p1)
  );

  pfd_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          emit;
  logic          emit_neg;
  logic          emit_sat;
  logic [CW-1:0] emit_mag;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    emit     = 1'b0;
    emit_neg = 1'b0;
    emit_sat = 1'b0;
    emit_mag = '0;
    case (state)
      IDLE: begin
        if (rise_ref_p1 && rise_fb_p1) begin
          emit = 1'b1;
        end else if (rise_ref_p1) begin
          state_n = LEAD_REF;
          cnt_n   = CNT_ONE;
        end else if (rise_fb_p1) begin
          state_n = LEAD_FB;
          cnt_n   = CNT_ONE;
        end
      end
      LEAD_REF: begin
        if (rise_fb_p1) begin
          emit     = 1'b1;
          emit_mag = cnt;
          emit_sat = (cnt == CNT_MAX);
          // a coincident ref edge starts the next interval immediately
          if (rise_ref_p1) cnt_n   = CNT_ONE;
          else             state_n = IDLE;
        end else if (rise_ref_p1) begin
          // second ref edge with no fb: frequency slip, report full scale
          emit     = 1'b1;
          emit_mag = CNT_MAX;
          emit_sat = 1'b1;
          cnt_n    = CNT_ONE;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end
      LEAD_FB: begin
        emit_neg = 1'b1;
        if (rise_ref_p1) begin
          emit     = 1'b1;
          emit_mag = cnt;
          emit_sat = (cnt == CNT_MAX);
          if (rise_fb_p1) cnt_n   = CNT_ONE;
          else            state_n = IDLE;
        end else if (rise_fb_p1) begin
          emit     = 1'b1;
          emit_mag = CNT_MAX;
          emit_sat = 1'b1;
          cnt_n    = CNT_ONE;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---- stage p2: FSM state, counter and output registers ----
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      up        <= 1'b0;
      dn        <= 1'b0;
      err_valid <= 1'b0;
      sat       <= 1'b0;
      phase_err <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      up        <= (state_n == LEAD_REF);
      dn        <= (state_n == LEAD_FB);
      err_valid <= emit;
      if (emit) begin
        phase_err <= signed_mag(emit_mag, emit_neg);
        sat       <= emit_sat;
      end
    end
  end

endmodule

// File: tb/tb_digital_pfd_counter.sv
// ---------------------------------------------------------------------------
// tb_digital_pfd_counter
//   Self-checking bench. Inputs are driven on the falling edge of clk_in, one
//   value per cycle. A timestamp-based reference model works on the list of
//   input rising-edge times and predicts every phase_err update and every
//   up/dn level; a directed table and hand-written sequences cover the
//   corner cases.
// ---------------------------------------------------------------------------
module tb_digital_pfd_counter;

  localparam int ERR_WIDTH   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAX         = 127;
  // posedge that first samples an input edge -> posedge that updates outputs
  localparam int LAT         = SYNC_STAGES + 1;

  logic                        clk_in = 1'b0;
  logic                        rst_n;
  logic                        ref_clk;
  logic                        fb_clk;
  logic                        up;
  logic                        dn;
  logic signed [ERR_WIDTH-1:0] phase_err;
  logic                        err_valid;
  logic                        sat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  digital_pfd_counter #(
    .ERR_WIDTH   (ERR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .ref_clk   (ref_clk),
    .fb_clk    (fb_clk),
    .up        (up),
    .dn        (dn),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .sat       (sat)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int t; int err; bit sat; } emit_t;
  typedef struct { int t; bit up; bit dn; } lvl_t;

  emit_t exp_q[$];
  lvl_t  lvl_q[$];
  int    m_open  = 0;   // 0: no edge outstanding, 1: ref edge open, 2: fb edge open
  int    m_start = 0;   // time of the edge that opened the interval
  bit    prev_r  = 1'b0;
  bit    prev_f  = 1'b0;

  function automatic void push_emit(input int t, input int v, input bit s);
    emit_t e;
    e.t = t; e.err = v; e.sat = s;
    exp_q.push_back(e);
  endfunction

  // rr/rf: input rose at sample time p
  function automatic void model(input bit rr, input bit rf, input int p);
    bit   lead_again;
    bit   closer;
    int   sgn;
    int   k;
    lvl_t l;
    if (m_open == 0) begin
      if (rr && rf) push_emit(p + LAT, 0, 1'b0);
      else if (rr) begin m_open = 1; m_start = p; end
      else if (rf) begin m_open = 2; m_start = p; end
    end else begin
      lead_again = (m_open == 1) ? rr : rf;
      closer     = (m_open == 1) ? rf : rr;
      sgn        = (m_open == 1) ? 1 : -1;
      if (closer) begin
        k = p - m_start;
        push_emit(p + LAT, sgn * ((k > MAX) ? MAX : k), k >= MAX);
        if (lead_again) m_start = p;
        else            m_open  = 0;
      end else if (lead_again) begin
        push_emit(p + LAT, sgn * MAX, 1'b1);
        m_start = p;
      end
    end
    l.t = p + LAT; l.up = (m_open == 1); l.dn = (m_open == 2);
    lvl_q.push_back(l);
  endfunction

  task automatic step(input bit r, input bit f);
    @(negedge clk_in);
    ref_clk = r;
    fb_clk  = f;
    model(r & ~prev_r, f & ~prev_f, cyc + 1);
    prev_r = r;
    prev_f = f;
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n   = 1'b0;
    ref_clk = 1'b0;
    fb_clk  = 1'b0;
    m_open  = 0;
    prev_r  = 1'b0;
    prev_f  = 1'b0;
    exp_q.delete();
    lvl_q.delete();
    #1;
    chk("rst_up", up, 0);
    chk("rst_dn", dn, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_sat", sat, 0);
    chk("rst_phase_err", int'(phase_err), 0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int up_total = 0;
  int dn_total = 0;
  int log_err[$];
  bit log_sat[$];

  always @(negedge clk_in) begin
    if (up) up_total++;
    if (dn) dn_total++;
    if (err_valid) begin
      log_err.push_back(int'(phase_err));
      log_sat.push_back(sat);
    end
    while (lvl_q.size() > 0 && lvl_q[0].t < cyc) void'(lvl_q.pop_front());
    if (lvl_q.size() > 0 && lvl_q[0].t == cyc) begin
      chk("up_level", up, lvl_q[0].up);
      chk("dn_level", dn, lvl_q[0].dn);
      void'(lvl_q.pop_front());
    end
    while (exp_q.size() > 0 && exp_q[0].t < cyc) void'(exp_q.pop_front());
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      chk("err_valid_pulse", err_valid, 1);
      chk("phase_err", int'(phase_err), exp_q[0].err);
      chk("sat", sat, exp_q[0].sat);
      void'(exp_q.pop_front());
    end else begin
      chk("err_valid_quiet", err_valid, 0);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    bit ref_first;
    int gap;
    int exp_err;
    bit exp_sat;
    int exp_up;
    int exp_dn;
  } vec_t;

  task automatic run_pair(input vec_t v);
    int  n0, u0, d0;
    bit  lr, lf;
    n0 = log_err.size(); u0 = up_total; d0 = dn_total;
    lr = v.ref_first;
    lf = ~v.ref_first;
    if (v.gap == 0) step(1'b1, 1'b1);
    else begin
      step(lr, lf);
      repeat (v.gap - 1) step(lr, lf);
      step(1'b1, 1'b1);
    end
    repeat (2) step(1'b1, 1'b1);
    repeat (LAT + 5) step(1'b0, 1'b0);
    chk($sformatf("gap%0d_count", v.gap), log_err.size() - n0, 1);
    if (log_err.size() > n0) begin
      chk($sformatf("gap%0d_err", v.gap), log_err[log_err.size()-1], v.exp_err);
      chk($sformatf("gap%0d_sat", v.gap), log_sat[log_sat.size()-1], v.exp_sat);
    end
    chk($sformatf("gap%0d_up_cycles", v.gap), up_total - u0, v.exp_up);
    chk($sformatf("gap%0d_dn_cycles", v.gap), dn_total - d0, v.exp_dn);
  endtask

  vec_t vecs[9];

  initial begin
    bit r, f;
    int n0, u0, d0;

    vecs[0] = '{1'b1,   5,    5, 1'b0,   5,   0};
    vecs[1] = '{1'b0,   3,   -3, 1'b0,   0,   3};
    vecs[2] = '{1'b1,   0,    0, 1'b0,   0,   0};
    vecs[3] = '{1'b1, 200,  127, 1'b1, 200,   0};
    vecs[4] = '{1'b0, 200, -127, 1'b1,   0, 200};
    vecs[5] = '{1'b1,   1,    1, 1'b0,   1,   0};
    vecs[6] = '{1'b0, 126, -126, 1'b0,   0, 126};
    vecs[7] = '{1'b1, 127,  127, 1'b1, 127,   0};
    vecs[8] = '{1'b0, 128, -127, 1'b1,   0, 128};

    rst_n   = 1'b0;
    ref_clk = 1'b0;
    fb_clk  = 1'b0;
    apply_reset();
    repeat (3) step(1'b0, 1'b0);

    foreach (vecs[i]) run_pair(vecs[i]);

    // frequency slip: two ref edges 10 apart, then fb 4 cycles after the second
    n0 = log_err.size(); u0 = up_total;
    step(1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    repeat (LAT + 5) step(1'b0, 1'b0);
    chk("slip_count", log_err.size() - n0, 2);
    if (log_err.size() >= n0 + 2) begin
      chk("slip_err", log_err[n0], 127);
      chk("slip_sat", log_sat[n0], 1);
      chk("after_slip_err", log_err[n0+1], 4);
      chk("after_slip_sat", log_sat[n0+1], 0);
    end
    chk("slip_up_cycles", up_total - u0, 14);

    // reset in the middle of a ref-led interval, then a fb-led measurement
    repeat (6) step(1'b1, 1'b0);
    chk("pre_reset_up", up, 1);
    n0 = log_err.size();
    apply_reset();
    repeat (3) step(1'b0, 1'b0);
    d0 = dn_total;
    repeat (6) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (LAT + 5) step(1'b0, 1'b0);
    chk("post_reset_count", log_err.size() - n0, 1);
    if (log_err.size() > n0) chk("post_reset_err", log_err[n0], -6);
    chk("post_reset_dn_cycles", dn_total - d0, 6);

    // random: dense edges (coincidences, short gaps, slips)
    r = 1'b0; f = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(5) == 0) r = ~r;
      if ($urandom_range(5) == 0) f = ~f;
      step(r, f);
    end
    // random: sparse edges (long gaps, saturation)
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(179) == 0) r = ~r;
      if ($urandom_range(179) == 0) f = ~f;
      step(r, f);
    end
    repeat (LAT + 6) step(1'b0, 1'b0);
    chk("pending_emits", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
